// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32I width codes, FSM states, word size.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic: store merge into an existing word and load extract/extend.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  output logic [31:0] new_word,
  output logic [31:0] rdata
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign sel_byte = word[{lane, 3'b000} +: 8];
  assign sel_half = lane[1] ? word[31:16] : word[15:0];

  always_comb begin
    new_word = word;
    case (funct3)
      F3_B:    new_word[{lane, 3'b000} +: 8] = wdata[7:0];
      F3_H:    new_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      F3_W:    new_word = wdata;
      default: new_word = word;
    endcase
  end

  always_comb begin
    rdata = '0;
    case (funct3)
      F3_B:    rdata = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   rdata = {24'h000000, sel_byte};
      F3_H:    rdata = {{16{sel_half[15]}}, sel_half};
      F3_HU:   rdata = {16'h0000, sel_half};
      F3_W:    rdata = word;
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency handshaked data-memory slave for RV32I loads/stores.
// Define DMEM_MISALIGN_ERR_EN to fault misaligned halfword/word accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 16384,
  parameter int unsigned LATENCY   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int unsigned IdxW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  state_e      state;
  logic [3:0]  cnt;
  logic        write_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [NUM_WORDS];

  logic        cur_write;
  logic [2:0]  cur_funct3;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        enter_resp;
  logic        in_range;
  logic        f3_ok;
  logic        misalign;
  logic        err;
  logic        mem_we;
  logic [31:0] rd_word;
  logic [31:0] merged_word;
  logic [31:0] load_data;
  logic [31:0] resp_data_d;

  // With LATENCY=1 the commit edge is the acceptance edge, so use the live request.
  assign cur_write  = (state == S_IDLE) ? req_write  : write_q;
  assign cur_funct3 = (state == S_IDLE) ? req_funct3 : funct3_q;
  assign cur_addr   = (state == S_IDLE) ? req_addr   : addr_q;
  assign cur_wdata  = (state == S_IDLE) ? req_wdata  : wdata_q;

  assign enter_resp = ((state == S_IDLE) && req_valid && (LATENCY == 1)) ||
                      ((state == S_BUSY) && (cnt == 4'd0));

  assign in_range = ({2'b00, cur_addr[31:2]} < NUM_WORDS);
  assign f3_ok    = (cur_funct3 == F3_B) || (cur_funct3 == F3_H) || (cur_funct3 == F3_W) ||
                    (!cur_write && ((cur_funct3 == F3_BU) || (cur_funct3 == F3_HU)));

`ifdef DMEM_MISALIGN_ERR_EN
  assign misalign = (((cur_funct3 == F3_H) || (cur_funct3 == F3_HU)) && cur_addr[0]) ||
                    ((cur_funct3 == F3_W) && (cur_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign err         = !in_range || !f3_ok || misalign;
  assign rd_word     = mem[cur_addr[IdxW+1:2]];
  assign mem_we      = enter_resp && cur_write && !err;
  assign resp_data_d = (cur_write || err) ? 32'h0 : load_data;

  dmem_lane_align u_lane_align (
    .word     (rd_word),
    .wdata    (cur_wdata),
    .funct3   (cur_funct3),
    .lane     (cur_addr[1:0]),
    .new_word (merged_word),
    .rdata    (load_data)
  );

  // Array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[cur_addr[IdxW+1:2]] <= merged_word;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_error <= 1'b0;
      write_q    <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            write_q   <= req_write;
            funct3_q  <= req_funct3;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (LATENCY == 1) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_rdata <= resp_data_d;
              resp_error <= err;
            end else begin
              cnt   <= 4'(LATENCY - 2);
              state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (cnt == 4'd0) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= resp_data_d;
            resp_error <= err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_error <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
